// File: rtl/mac_pkg.sv
// Shared types for the iterative multiply/accumulate unit:
// operation encodings, FSM states and the operation decoder.
package mac_pkg;

   localparam logic [2:0] MAC_MUL   = 3'b000;
   localparam logic [2:0] MAC_MLA   = 3'b001;
   localparam logic [2:0] MAC_UMULL = 3'b100;
   localparam logic [2:0] MAC_UMLAL = 3'b101;
   localparam logic [2:0] MAC_SMULL = 3'b110;
   localparam logic [2:0] MAC_SMLAL = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   typedef struct packed {
      logic is_long;
      logic is_signed;
      logic is_acc;
      logic illegal;
   } mac_dec_t;

   function automatic mac_dec_t mac_decode(input logic [2:0] t);
      mac_dec_t d;
      d = '0;
      unique case (t)
         MAC_MUL:   d = '0;
         MAC_MLA:   d.is_acc = 1'b1;
         MAC_UMULL: d.is_long = 1'b1;
         MAC_UMLAL: begin d.is_long = 1'b1; d.is_acc = 1'b1; end
         MAC_SMULL: begin d.is_long = 1'b1; d.is_signed = 1'b1; end
         MAC_SMLAL: begin
            d.is_long   = 1'b1;
            d.is_signed = 1'b1;
            d.is_acc    = 1'b1;
         end
         default:   d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mac_step.sv
// One shift-add iteration: adds mcand times a BITS_PER_CYCLE-bit
// multiplier slice into the running 2*WIDTH accumulator.
module mac_step #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic [2*WIDTH-1:0]        acc,
   input  logic [2*WIDTH-1:0]        mcand,
   input  logic [BITS_PER_CYCLE-1:0] slice,
   output logic [2*WIDTH-1:0]        sum
);

   always_comb begin
      sum = acc;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (slice[i]) sum = sum + (mcand << i);
      end
   end

endmodule

// File: rtl/iterative_multiply_accumulate.sv
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit with a
// start/ready/done handshake; works on operand magnitudes.
module iterative_multiply_accumulate
   import mac_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   input  logic [2:0]           type_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   input  logic [WIDTH-1:0]     c_i,
   input  logic [WIDTH-1:0]     d_i,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 n_o,
   output logic                 z_o,
   output logic                 illegal_o
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   state_t             state, state_nxt;
   mac_dec_t           dec_in;
   logic               go, last;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   a_abs, b_abs, mplier, c_q, d_q;
   logic [2*WIDTH-1:0] acc, acc_nxt, mcand, prod, fin;
   logic               op_long, op_acc, op_ill, neg;
   logic               fin_n, fin_z;

   assign dec_in = mac_decode(type_i);
   // Unsigned magnitudes; 2^(WIDTH-1) still fits in WIDTH bits.
   assign a_abs = (dec_in.is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
   assign b_abs = (dec_in.is_signed && b_i[WIDTH-1]) ? -b_i : b_i;
   assign go    = start_i && ready_o;
   assign last  = (cnt == CW'(N));

   mac_step #(
      .WIDTH         (WIDTH),
      .BITS_PER_CYCLE(BITS_PER_CYCLE)
   ) u_step (
      .acc  (acc),
      .mcand(mcand),
      .slice(mplier[BITS_PER_CYCLE-1:0]),
      .sum  (acc_nxt)
   );

   always_comb begin
      prod = neg ? -acc : acc;
      fin  = '0;
      if (op_ill)
         fin = '0;
      else if (op_long)
         fin = prod + (op_acc ? {c_q, d_q} : '0);
      else
         fin = {{WIDTH{1'b0}}, prod[WIDTH-1:0] + (op_acc ? c_q : '0)};
   end

   assign fin_n = op_long ? fin[2*WIDTH-1] : fin[WIDTH-1];
   assign fin_z = op_long ? (fin == '0) : (fin[WIDTH-1:0] == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start_i) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    state_nxt = start_i ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready_o = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      unique case (state)
         IDLE:    ready_o = 1'b1;
         RUN:     busy_o  = 1'b1;
         DONE:    begin ready_o = 1'b1; done_o = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         c_q       <= '0;
         d_q       <= '0;
         op_long   <= 1'b0;
         op_acc    <= 1'b0;
         op_ill    <= 1'b0;
         neg       <= 1'b0;
         result_o  <= '0;
         n_o       <= 1'b0;
         z_o       <= 1'b0;
         illegal_o <= 1'b0;
      end else if (go) begin
         cnt     <= '0;
         acc     <= '0;
         mcand   <= {{WIDTH{1'b0}}, a_abs};
         mplier  <= b_abs;
         c_q     <= c_i;
         d_q     <= d_i;
         op_long <= dec_in.is_long;
         op_acc  <= dec_in.is_acc;
         op_ill  <= dec_in.illegal;
         neg     <= dec_in.is_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      end else if (state == RUN) begin
         if (!last) begin
            acc    <= acc_nxt;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= cnt + CW'(1);
         end else begin
            result_o  <= fin;
            n_o       <= fin_n;
            z_o       <= fin_z;
            illegal_o <= op_ill;
         end
      end
   end

endmodule

// File: tb/tb_iterative_multiply_accumulate.sv
// Bench for iterative_multiply_accumulate: arithmetic reference
// model, per-cycle output monitor, directed and random operations.
module tb_iterative_multiply_accumulate
   import mac_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 2
);

   localparam int N   = WIDTH / BITS_PER_CYCLE;
   localparam int TMO = 4 * (N + 2);

   typedef struct packed {
      logic [2*WIDTH-1:0] r;
      logic               n;
      logic               z;
      logic               ill;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start_i = 1'b0;
   logic [2:0]         type_i = '0;
   logic [WIDTH-1:0]   a_i = '0, b_i = '0, c_i = '0, d_i = '0;
   logic               ready_o, busy_o, done_o, n_o, z_o, illegal_o;
   logic [2*WIDTH-1:0] result_o;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t q_exp[$];
   int   q_k[$];
   exp_t last;
   logic prev_done;

   iterative_multiply_accumulate #(
      .WIDTH         (WIDTH),
      .BITS_PER_CYCLE(BITS_PER_CYCLE)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start_i  (start_i),
      .type_i   (type_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .c_i      (c_i),
      .d_i      (d_i),
      .ready_o  (ready_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o),
      .n_o      (n_o),
      .z_o      (z_o),
      .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tmo_fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out after %0d cycles", nm, TMO);
   endtask

   // Plain-arithmetic reference: full-width products taken mod 2^(2W).
   function automatic exp_t model(input logic [2:0] t,
                                  input logic [WIDTH-1:0] a, b, c, d);
      exp_t               e;
      logic [2*WIDTH-1:0] ua, ub, sa, sb, p;
      logic [WIDTH-1:0]   lo;
      logic               lng;
      ua  = {{WIDTH{1'b0}}, a};
      ub  = {{WIDTH{1'b0}}, b};
      sa  = {{WIDTH{a[WIDTH-1]}}, a};
      sb  = {{WIDTH{b[WIDTH-1]}}, b};
      e   = '0;
      lng = 1'b1;
      lo  = '0;
      p   = '0;
      case (t)
         MAC_MUL:   begin lo = a * b; p = {{WIDTH{1'b0}}, lo}; lng = 1'b0; end
         MAC_MLA:   begin lo = a * b + c; p = {{WIDTH{1'b0}}, lo}; lng = 1'b0; end
         MAC_UMULL: p = ua * ub;
         MAC_UMLAL: p = ua * ub + {c, d};
         MAC_SMULL: p = sa * sb;
         MAC_SMLAL: p = sa * sb + {c, d};
         default:   begin p = '0; lng = 1'b0; e.ill = 1'b1; end
      endcase
      e.r = p;
      e.n = lng ? p[2*WIDTH-1] : p[WIDTH-1];
      e.z = lng ? (p == '0) : (p[WIDTH-1:0] == '0);
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      int   k;
      logic pend;
      if (reset) begin
         last      = '0;
         prev_done = 1'b0;
      end else begin
         pend = (q_exp.size() != 0);
         chk("busy", busy_o, pend && !done_o);
         chk("ready", ready_o, !(pend && !done_o));
         if (done_o) begin
            if (prev_done) chk("done_pulse_width", 1'b1, 1'b0);
            if (!pend) begin
               chk("spurious_done", done_o, 1'b0);
            end else begin
               e = q_exp.pop_front();
               k = q_k.pop_front();
               chk("result", result_o, e.r);
               chk("flags_nzi", {n_o, z_o, illegal_o}, {e.n, e.z, e.ill});
               chk("latency", cyc - k, N + 1);
               last = e;
            end
         end else begin
            chk("hold", {result_o, n_o, z_o, illegal_o}, last);
         end
         prev_done = done_o;
      end
   end

   task automatic issue(input logic [2:0] t,
                        input logic [WIDTH-1:0] a, b, c, d);
      int w;
      int k;
      w = 0;
      @(negedge clk);
      while (!ready_o && w < TMO) begin
         @(negedge clk);
         w++;
      end
      if (!ready_o) begin
         tmo_fail("ready_wait");
         return;
      end
      start_i = 1'b1;
      type_i  = t;
      a_i = a; b_i = b; c_i = c; d_i = d;
      k = cyc + 1;
      @(posedge clk);
      q_exp.push_back(model(t, a, b, c, d));
      q_k.push_back(k);
      #1;
      start_i = 1'b0;
      a_i = '0; b_i = '0; c_i = '0; d_i = '0;
   endtask

   task automatic dir(input logic [2:0] t,
                      input logic [WIDTH-1:0] a, b, c, d,
                      input logic [2*WIDTH-1:0] lit_r,
                      input logic [2:0] lit_f);
      exp_t e;
      e = model(t, a, b, c, d);
      chk("model_lit_result", e.r, lit_r);
      chk("model_lit_flags", {e.n, e.z, e.ill}, lit_f);
      issue(t, a, b, c, d);
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (q_exp.size() != 0 && w < TMO) begin
         @(negedge clk);
         w++;
      end
      if (q_exp.size() != 0) tmo_fail("idle_wait");
      @(negedge clk);
   endtask

   function automatic logic [WIDTH-1:0] rnd_op();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(WIDTH-1){1'b0}}};
         default: return r[WIDTH-1:0];
      endcase
   endfunction

   logic [WIDTH-1:0]   all1;
   logic [WIDTH-1:0]   minv;
   logic [2*WIDTH-1:0] one2w;

   initial begin
      all1  = '1;
      minv  = {1'b1, {(WIDTH-1){1'b0}}};
      one2w = 1;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", ready_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_outs", {result_o, n_o, z_o, illegal_o}, '0);
      @(negedge clk);
      #2 reset = 1'b0;

      dir(MAC_MUL, 7, 6, 0, 0, 42, 3'b000);
      wait_idle();
      dir(MAC_MLA, all1, 2, 5, 0, 3, 3'b000);
      dir(MAC_UMULL, all1, all1, 0, 0, {all1 - 1'b1, WIDTH'(1)}, 3'b100);
      dir(MAC_SMULL, minv, minv, 0, 0, one2w << (2*WIDTH-2), 3'b000);
      dir(MAC_SMLAL, all1, 2, 0, 2, '0, 3'b010);
      dir(MAC_UMLAL, 1, 1, all1, all1, '0, 3'b010);
      dir(3'b010, 9, 9, 1, 1, '0, 3'b011);
      dir(3'b011, all1, all1, all1, all1, '0, 3'b011);
      dir(MAC_SMULL, all1, 3, 0, 0, '1 - 2'd2, 3'b100);
      wait_idle();

      issue(MAC_MUL, 100, 3, 0, 0);
      repeat (3) @(negedge clk);
      start_i = 1'b1;
      type_i  = MAC_UMULL;
      a_i = all1; b_i = all1; c_i = all1; d_i = all1;
      @(negedge clk);
      start_i = 1'b0;
      wait_idle();
      chk("busy_start_ignored", result_o, 300);

      issue(MAC_UMULL, all1, all1, 0, 0);
      repeat (8) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_ready", ready_o, 1'b1);
      chk("midrst_busy", busy_o, 1'b0);
      chk("midrst_done", done_o, 1'b0);
      chk("midrst_outs", {result_o, n_o, z_o, illegal_o}, '0);
      q_exp.delete();
      q_k.delete();
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (N + 4) @(negedge clk);

      for (int i = 0; i < 1000; i++) begin
         issue(3'($urandom_range(0, 7)), rnd_op(), rnd_op(), rnd_op(), rnd_op());
      end
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
